dsp_pre_adder_stage: RTL and testbench
======================================

# dsp_pre_adder_stage

- Input stage of the DSP48A1 datapath: registers the A, B/BCIN, D and OPMODE inputs, forms the 18-bit D±B pre-add, and delivers the A1/B1 multiplier operands plus the registered OPMODE word to the downstream multiplier and X/Z operand-select muxes.
- Every register stage is parameter-selectable as registered or bypassed; each has its own clock enable.
- All registers share one synchronous reset.

## Interface
Parameters:
- A0REG, 0, 1 = register A in stage 0; 0 = bypass
- A1REG, 1, 1 = register A in stage 1
- B0REG, 0, 1 = register selected B in stage 0
- B1REG, 1, 1 = register B1 (post pre-adder)
- DREG, 1, 1 = register D
- OPMODEREG, 1, 1 = register OPMODE
- B_INPUT, "DIRECT", "CASCADE" selects BCIN; any other value selects B

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset, all registers of this block
- A  in  18  A operand
- B  in  18  B operand, direct
- BCIN  in  18  B operand from the upstream slice cascade
- D  in  18  pre-adder operand
- OPMODE  in  8  operation mode word
- CEA  in  1  enable for the A0 and A1 registers
- CEB  in  1  enable for the B0 and B1 registers
- CED  in  1  enable for the D register
- CEOPMODE  in  1  enable for the OPMODE register
- A1_OUT  out  18  A multiplier operand
- B1_OUT  out  18  B multiplier operand
- BCOUT  out  18  cascade output; always equal to B1_OUT
- OPMODE_OUT  out  8  OPMODE after the optional register; drives all downstream mux selects

## Operation
- Bsel = BCIN if B_INPUT == "CASCADE", else B.
- Each stage X is one of two forms, chosen by the parameter:
  - Registered (param = 1): on each CLK edge, if RST then X_r <= 0; else if CE then X_r <= input; else hold.
  - Bypassed (param = 0): the stage is a wire; RST and CE have no effect on it.
- Stage chain:
  - A0 = stage(A, A0REG, CEA); A1_OUT = stage(A0, A1REG, CEA).
  - B0 = stage(Bsel, B0REG, CEB); D0 = stage(D, DREG, CED).
  - OPMODE_OUT = stage(OPMODE, OPMODEREG, CEOPMODE).
- Pre-adder uses OPMODE_OUT:
  - bit 6 = 1: P = D0 − B0; bit 6 = 0: P = D0 + B0.
  - Unsigned 18-bit, modulo 2^18. No carry-out, no saturation; wrap is silent.
- B1in = P if OPMODE_OUT[4] = 1, else B0. B1_OUT = stage(B1in, B1REG, CEB).
- BCOUT = B1_OUT, unconditionally.
- RST has priority over every CE.
- Reset values: all registered outputs 0. Bypassed outputs follow their inputs combinationally even while RST is high.

## Timing
- Latency with defaults:
  - A→A1_OUT: 1 cycle.
  - B→B1_OUT: 1 cycle.
  - D→B1_OUT: 2 cycles.
  - OPMODE→OPMODE_OUT: 1 cycle.
- General latency = sum of enabled register parameters along the path.
- OPMODE timing, defaults: OPMODE applied at edge t is registered at t. Its bits 6 and 4 then steer the pre-add captured into B1 at edge t+1.
- OPMODE timing, OPMODEREG = 0: bits 6 and 4 act within the same cycle.
- CE low holds a stage for any number of cycles. Downstream stages whose CE stays high keep capturing the held value.
- RST asserted mid-stream: every registered stage reads 0 on the next edge. The first valid data appears one full path latency after RST deasserts, with CEs high.
- RST and CE both high on the same edge: output 0.
- No handshake. Every input is sampled on every enabled edge.

## Structure
- Shared package `dsp48a1_pkg`:
  - `DATA_W` = 18, `OPMODE_W` = 8.
  - OPMODE bit indices `OPM_PREADD_SUB` = 6, `OPM_PREADD_SEL` = 4.
  - B_INPUT string constants.
- One sub-module `reg_bypass_stage`, with parameters WIDTH and REG and ports CLK, RST, CE, D, Q. It is instantiated six times.
- Pre-adder and the B1 source select are inline combinational logic.

## Test plan
- Reset: drive non-zero inputs, all CEs = 1, RST = 1 for 2 cycles → A1_OUT, B1_OUT, BCOUT and OPMODE_OUT are all 0 on the edge after RST is sampled.
- Pre-add (defaults): D = 0x00010, B = 0x00003, OPMODE = 0x10 → B1_OUT = 0x00013 at 2 cycles after D is applied. With OPMODE = 0x50 → 0x0000D.
- Subtract wrap: D = 0, B = 1, OPMODE = 0x50 → B1_OUT = 0x3FFFF. Add wrap: D = 0x3FFFF, B = 1, OPMODE = 0x10 → 0x00000.
- Bypass: A0REG = A1REG = 0 → A1_OUT tracks A in the same cycle, including while RST = 1. B_INPUT = "CASCADE", BCIN = 0x2AAAA, OPMODE[4] = 0 → B1_OUT and BCOUT = 0x2AAAA after 1 cycle.
- CE hold: CEB = 0 for 3 cycles while B changes → B1_OUT holds its prior value. CEB = 1 → new value appears after 1 cycle.
- RST vs CE: RST = 1 and CEA = 1 on the same edge with A = 0x12345 → A1_OUT = 0.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 slice datapath: bus widths, the OPMODE
// bit positions that steer the pre-adder, and the B-input source names.
package dsp48a1_pkg;

  localparam int DATA_W   = 18;
  localparam int OPMODE_W = 8;

  // OPMODE bit that turns the pre-adder from D+B into D-B
  localparam int OPM_PREADD_SUB = 6;
  // OPMODE bit that routes the pre-adder result (rather than B0) into B1
  localparam int OPM_PREADD_SEL = 4;

  localparam string B_INPUT_DIRECT  = "DIRECT";
  localparam string B_INPUT_CASCADE = "CASCADE";

endpackage

// File: rtl/dsp_pre_adder_stage_if.sv
// Operand bus between the slice input pins and the pre-adder stage.
// The master side drives operands, enables and OPMODE and receives the
// multiplier operands; the slave side is the pre-adder stage itself.
interface dsp_pre_adder_stage_if;
  import dsp48a1_pkg::*;

  logic [DATA_W-1:0]   A;
  logic [DATA_W-1:0]   B;
  logic [DATA_W-1:0]   BCIN;
  logic [DATA_W-1:0]   D;
  logic [OPMODE_W-1:0] OPMODE;
  logic                CEA;
  logic                CEB;
  logic                CED;
  logic                CEOPMODE;
  logic [DATA_W-1:0]   A1_OUT;
  logic [DATA_W-1:0]   B1_OUT;
  logic [DATA_W-1:0]   BCOUT;
  logic [OPMODE_W-1:0] OPMODE_OUT;

  modport master (
    output A, B, BCIN, D, OPMODE, CEA, CEB, CED, CEOPMODE,
    input  A1_OUT, B1_OUT, BCOUT, OPMODE_OUT
  );

  modport slave (
    input  A, B, BCIN, D, OPMODE, CEA, CEB, CED, CEOPMODE,
    output A1_OUT, B1_OUT, BCOUT, OPMODE_OUT
  );

endinterface

// File: rtl/reg_bypass_stage.sv
// One pipeline stage that is either a clock-enabled register with
// synchronous reset (REG != 0) or a plain wire (REG == 0). In the wire
// form reset and enable are ignored, so the output follows D at all times.
module reg_bypass_stage #(
  parameter int          WIDTH = 18,
  parameter int unsigned REG   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  generate
    if (REG != 0) begin : g_reg
      logic [WIDTH-1:0] r_q;

      // Reset wins over enable; without enable the stage holds its value
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_q <= '0;
        end else if (CE) begin
          r_q <= D;
        end else begin
          r_q <= r_q;
        end
      end

      assign Q = r_q;
    end else begin : g_byp
      // Control inputs have no function in the wire form
      logic w_unused_ctrl;
      assign w_unused_ctrl = ^{CLK, RST, CE};
      assign Q = D;
    end
  endgenerate

endmodule

// File: rtl/dsp_pre_adder_stage.sv
// DSP48A1 input stage: optional A0/A1, B0, D, OPMODE and B1 registers,
// the 18-bit D+/-B pre-adder and the B1 source select. OPMODE_OUT is the
// post-register OPMODE word, and it is that word (not the raw pin) that
// steers the pre-adder, so with OPMODEREG=1 a new mode takes effect one
// edge after it is applied.
module dsp_pre_adder_stage
  import dsp48a1_pkg::*;
#(
  parameter int unsigned A0REG     = 0,
  parameter int unsigned A1REG     = 1,
  parameter int unsigned B0REG     = 0,
  parameter int unsigned B1REG     = 1,
  parameter int unsigned DREG      = 1,
  parameter int unsigned OPMODEREG = 1,
  parameter string       B_INPUT   = B_INPUT_DIRECT
) (
  input  logic                  CLK,
  input  logic                  RST,
  dsp_pre_adder_stage_if.slave  bus
);

  // Anything other than the cascade name selects the direct B pin
  localparam bit USE_CASCADE = (B_INPUT == B_INPUT_CASCADE);

  logic [DATA_W-1:0]   w_a0;
  logic [DATA_W-1:0]   w_a1;
  logic [DATA_W-1:0]   w_bsel;
  logic [DATA_W-1:0]   w_b0;
  logic [DATA_W-1:0]   w_d0;
  logic [OPMODE_W-1:0] w_opmode;
  logic [DATA_W-1:0]   w_preadd;
  logic [DATA_W-1:0]   w_b1_in;
  logic [DATA_W-1:0]   w_b1;

  assign w_bsel = USE_CASCADE ? bus.BCIN : bus.B;

  reg_bypass_stage #(.WIDTH(DATA_W), .REG(A0REG)) u_a0 (
    .CLK(CLK), .RST(RST), .CE(bus.CEA), .D(bus.A), .Q(w_a0)
  );

  reg_bypass_stage #(.WIDTH(DATA_W), .REG(A1REG)) u_a1 (
    .CLK(CLK), .RST(RST), .CE(bus.CEA), .D(w_a0), .Q(w_a1)
  );

  reg_bypass_stage #(.WIDTH(DATA_W), .REG(B0REG)) u_b0 (
    .CLK(CLK), .RST(RST), .CE(bus.CEB), .D(w_bsel), .Q(w_b0)
  );

  reg_bypass_stage #(.WIDTH(DATA_W), .REG(DREG)) u_d0 (
    .CLK(CLK), .RST(RST), .CE(bus.CED), .D(bus.D), .Q(w_d0)
  );

  reg_bypass_stage #(.WIDTH(OPMODE_W), .REG(OPMODEREG)) u_opmode (
    .CLK(CLK), .RST(RST), .CE(bus.CEOPMODE), .D(bus.OPMODE), .Q(w_opmode)
  );

  // Pre-add (wraps modulo 2^18, no carry out) and choice of B1 source
  always_comb begin
    w_preadd = '0;
    w_b1_in  = w_b0;
    if (w_opmode[OPM_PREADD_SUB]) begin
      w_preadd = w_d0 - w_b0;
    end else begin
      w_preadd = w_d0 + w_b0;
    end
    if (w_opmode[OPM_PREADD_SEL]) begin
      w_b1_in = w_preadd;
    end else begin
      w_b1_in = w_b0;
    end
  end

  // B1 shares the B clock enable with B0
  reg_bypass_stage #(.WIDTH(DATA_W), .REG(B1REG)) u_b1 (
    .CLK(CLK), .RST(RST), .CE(bus.CEB), .D(w_b1_in), .Q(w_b1)
  );

  assign bus.A1_OUT     = w_a1;
  assign bus.B1_OUT     = w_b1;
  assign bus.BCOUT      = w_b1;
  assign bus.OPMODE_OUT = w_opmode;

endmodule

// File: tb/tb_dsp_pre_adder_stage.sv
// Bench for dsp_pre_adder_stage. Two instances share one set of inputs:
//   dut0 - default parameters, direct B
//   dut1 - A path and D/OPMODE bypassed, B taken from the cascade input
// A behavioural model tracks what each instance must hold, and outputs are
// compared on every falling edge; directed cases pin known values.
module tb_dsp_pre_adder_stage;

  localparam int MOD = 262144;

  logic        CLK;
  logic        t_rst;
  logic [17:0] t_a, t_b, t_bcin, t_d;
  logic [7:0]  t_opmode;
  logic        t_cea, t_ceb, t_ced, t_ceop;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  dsp_pre_adder_stage_if if0 ();
  dsp_pre_adder_stage_if if1 ();

  assign if0.A = t_a;       assign if1.A = t_a;
  assign if0.B = t_b;       assign if1.B = t_b;
  assign if0.BCIN = t_bcin; assign if1.BCIN = t_bcin;
  assign if0.D = t_d;       assign if1.D = t_d;
  assign if0.OPMODE = t_opmode;  assign if1.OPMODE = t_opmode;
  assign if0.CEA = t_cea;   assign if1.CEA = t_cea;
  assign if0.CEB = t_ceb;   assign if1.CEB = t_ceb;
  assign if0.CED = t_ced;   assign if1.CED = t_ced;
  assign if0.CEOPMODE = t_ceop;  assign if1.CEOPMODE = t_ceop;

  dsp_pre_adder_stage dut0 (.CLK(CLK), .RST(t_rst), .bus(if0));

  dsp_pre_adder_stage #(
    .A0REG(0), .A1REG(0), .B0REG(0), .B1REG(1),
    .DREG(0), .OPMODEREG(0), .B_INPUT("CASCADE")
  ) dut1 (.CLK(CLK), .RST(t_rst), .bus(if1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Which stages are registered in each instance
  bit cfg_a0 [2] = '{1'b0, 1'b0};
  bit cfg_a1 [2] = '{1'b1, 1'b0};
  bit cfg_b0 [2] = '{1'b0, 1'b0};
  bit cfg_b1 [2] = '{1'b1, 1'b1};
  bit cfg_d  [2] = '{1'b1, 1'b0};
  bit cfg_op [2] = '{1'b1, 1'b0};
  bit cfg_cs [2] = '{1'b0, 1'b1};

  typedef struct {
    logic [17:0] a0, a1, b0, d0, b1;
    logic [7:0]  op;
  } mst_t;

  typedef struct {
    logic [17:0] a0, a1out, bsel, b0, d0, b1in, b1out;
    logic [7:0]  op;
  } mview_t;

  mst_t ms [2];

  // What each point of the path must show, given held state and the pins
  function automatic mview_t model_view(int c, mst_t s);
    mview_t m;
    int     sum;
    m.a0    = cfg_a0[c] ? s.a0 : t_a;
    m.a1out = cfg_a1[c] ? s.a1 : m.a0;
    m.bsel  = cfg_cs[c] ? t_bcin : t_b;
    m.b0    = cfg_b0[c] ? s.b0 : m.bsel;
    m.d0    = cfg_d[c]  ? s.d0 : t_d;
    m.op    = cfg_op[c] ? s.op : t_opmode;
    if (m.op[6]) sum = int'({14'd0, m.d0}) - int'({14'd0, m.b0});
    else         sum = int'({14'd0, m.d0}) + int'({14'd0, m.b0});
    if (sum < 0)    sum = sum + MOD;
    if (sum >= MOD) sum = sum - MOD;
    m.b1in  = m.op[4] ? 18'(sum) : m.b0;
    m.b1out = cfg_b1[c] ? s.b1 : m.b1in;
    return m;
  endfunction

  task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on each rising edge
  always @(posedge CLK) begin : model_upd
    mview_t v;
    mst_t   nx;
    for (int c = 0; c < 2; c++) begin
      v  = model_view(c, ms[c]);
      nx = ms[c];
      if (t_rst) begin
        nx = '{a0: 18'd0, a1: 18'd0, b0: 18'd0, d0: 18'd0, b1: 18'd0, op: 8'd0};
      end else begin
        if (t_cea)  begin nx.a0 = t_a;    nx.a1 = v.a0;   end
        if (t_ceb)  begin nx.b0 = v.bsel; nx.b1 = v.b1in; end
        if (t_ced)  nx.d0 = t_d;
        if (t_ceop) nx.op = t_opmode;
      end
      ms[c] <= nx;
    end
  end

  // Every falling edge: all outputs of both instances against the model
  always @(negedge CLK) begin : compare
    mview_t v0, v1;
    if (chk_en) begin
      v0 = model_view(0, ms[0]);
      v1 = model_view(1, ms[1]);
      chk("dut0_a1",   if0.A1_OUT, v0.a1out);
      chk("dut0_b1",   if0.B1_OUT, v0.b1out);
      chk("dut0_bc",   if0.BCOUT,  v0.b1out);
      chk("dut0_op",   {10'd0, if0.OPMODE_OUT}, {10'd0, v0.op});
      chk("dut1_a1",   if1.A1_OUT, v1.a1out);
      chk("dut1_b1",   if1.B1_OUT, v1.b1out);
      chk("dut1_bc",   if1.BCOUT,  v1.b1out);
      chk("dut1_op",   {10'd0, if1.OPMODE_OUT}, {10'd0, v1.op});
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  initial begin
    t_rst = 1'b1;
    t_a = 18'h1ABCD; t_b = 18'h00777; t_bcin = 18'h00555; t_d = 18'h00321;
    t_opmode = 8'h5A;
    t_cea = 1'b1; t_ceb = 1'b1; t_ced = 1'b1; t_ceop = 1'b1;

    // Reset with non-zero inputs and all enables high
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_a1",  if0.A1_OUT, 18'h00000);
    chk("rst_b1",  if0.B1_OUT, 18'h00000);
    chk("rst_bc",  if0.BCOUT,  18'h00000);
    chk("rst_op",  {10'd0, if0.OPMODE_OUT}, 18'h00000);
    chk("rst_byp_a1", if1.A1_OUT, 18'h1ABCD);

    // Pre-add with default pipelining: D+B, then D-B
    t_rst = 1'b0; t_bcin = 18'h00000;
    t_d = 18'h00010; t_b = 18'h00003; t_opmode = 8'h10;
    step(2);
    chk("preadd_add", if0.B1_OUT, 18'h00013);
    chk("preadd_op",  {10'd0, if0.OPMODE_OUT}, 18'h00010);
    t_opmode = 8'h50;
    step(2);
    chk("preadd_sub", if0.B1_OUT, 18'h0000D);

    // Wrap in both directions
    t_d = 18'h00000; t_b = 18'h00001; t_opmode = 8'h50;
    step(2);
    chk("sub_wrap", if0.B1_OUT, 18'h3FFFF);
    t_d = 18'h3FFFF; t_b = 18'h00001; t_opmode = 8'h10;
    step(2);
    chk("add_wrap", if0.B1_OUT, 18'h00000);

    // Cascade input through the bypassed-B0 instance
    t_bcin = 18'h2AAAA; t_opmode = 8'h00;
    step(1);
    chk("casc_b1", if1.B1_OUT, 18'h2AAAA);
    chk("casc_bc", if1.BCOUT,  18'h2AAAA);

    // B clock enable low holds B1 while B changes
    t_b = 18'h00111;
    step(2);
    chk("ceb_pre", if0.B1_OUT, 18'h00111);
    t_ceb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_b = 18'h01000 + 18'(i);
      step(1);
      chk("ceb_hold", if0.B1_OUT, 18'h00111);
    end
    t_ceb = 1'b1; t_b = 18'h00999;
    step(1);
    chk("ceb_resume", if0.B1_OUT, 18'h00999);

    // Reset beats enable; bypassed A still follows the pin under reset
    t_rst = 1'b1; t_cea = 1'b1; t_a = 18'h12345;
    step(1);
    chk("rst_vs_ce", if0.A1_OUT, 18'h00000);
    chk("byp_rst_a", if1.A1_OUT, 18'h12345);
    t_a = 18'h0ABCD;
    #1;
    chk("byp_track", if1.A1_OUT, 18'h0ABCD);
    t_rst = 1'b0;
    step(1);

    // Randomised traffic with random enables and occasional reset
    for (int i = 0; i < 400; i++) begin
      t_rst    = ($urandom_range(0, 19) == 0);
      t_cea    = ($urandom_range(0, 3) != 0);
      t_ceb    = ($urandom_range(0, 3) != 0);
      t_ced    = ($urandom_range(0, 3) != 0);
      t_ceop   = ($urandom_range(0, 3) != 0);
      t_a      = 18'($urandom());
      t_b      = 18'($urandom());
      t_bcin   = 18'($urandom());
      t_d      = 18'($urandom());
      t_opmode = 8'($urandom());
      if ($urandom_range(0, 7) == 0) t_d = 18'h3FFFF;
      if ($urandom_range(0, 7) == 0) t_b = 18'h00000;
      step(1);
    end

    step(1);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
